// File: rtl/ps2_keypad_entry_ctrl.sv
// ps2_keypad_entry_ctrl
// Turns the PS/2 scan-code byte stream into a fixed-length BCD entry
// (spot ID / PIN). Prefix bytes (F0 break, E0 extended) are stripped,
// digits from the main row and the keypad are accepted, Backspace/Esc/Enter
// edit or finish the entry, and an idle partial entry is discarded after
// TIMEOUT_CYC cycles. A finished entry is held until entry_ack.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no digits collected; waiting for the first digit
// COLLECT | 1..NUM_DIGITS digits collected; editing, idle timer running
// HOLD    | complete entry presented on entry_code, waiting for ack
module ps2_keypad_entry_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 250000000,
  parameter int TW          = 28
) (
  input  logic                              sys_clk,
  input  logic                              reset,
  input  logic                              code_valid,
  input  logic [7:0]                        code_in,
  input  logic                              entry_ack,
  output logic [4*NUM_DIGITS-1:0]           entry_code,
  output logic                              entry_valid,
  output logic                              entry_abort,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              busy
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(NUM_DIGITS + 1);

  localparam logic [7:0]    BYTE_BRK  = 8'hF0;
  localparam logic [7:0]    BYTE_EXT  = 8'hE0;
  localparam logic [7:0]    KEY_ENTER = 8'h5A;
  localparam logic [7:0]    KEY_BKSP  = 8'h66;
  localparam logic [7:0]    KEY_ESC   = 8'h76;

  localparam logic [CW-1:0] CNT_FULL  = CW'(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] code_q, code_n;
  logic [CW-1:0] count_q, count_n;
  logic [TW-1:0] timer_q, timer_n;
  logic          brk_q, brk_n;
  logic          ext_q, ext_n;
  logic          abort_q, abort_n;

  logic          digit_hit;
  logic [3:0]    digit_val;
  logic          enter_hit;
  logic          bksp_hit;
  logic          esc_hit;
  logic          key_byte;
  logic          key_any;
  logic [DW-1:0] code_shl;

  // Key classification of the current byte; only meaningful when key_byte is set.
  always_comb begin
    digit_hit = 1'b0;
    digit_val = 4'd0;
    if (!ext_q) begin
      case (code_in)
        8'h45, 8'h70: begin digit_hit = 1'b1; digit_val = 4'd0; end
        8'h16, 8'h69: begin digit_hit = 1'b1; digit_val = 4'd1; end
        8'h1E, 8'h72: begin digit_hit = 1'b1; digit_val = 4'd2; end
        8'h26, 8'h7A: begin digit_hit = 1'b1; digit_val = 4'd3; end
        8'h25, 8'h6B: begin digit_hit = 1'b1; digit_val = 4'd4; end
        8'h2E, 8'h73: begin digit_hit = 1'b1; digit_val = 4'd5; end
        8'h36, 8'h74: begin digit_hit = 1'b1; digit_val = 4'd6; end
        8'h3D, 8'h6C: begin digit_hit = 1'b1; digit_val = 4'd7; end
        8'h3E, 8'h75: begin digit_hit = 1'b1; digit_val = 4'd8; end
        8'h46, 8'h7D: begin digit_hit = 1'b1; digit_val = 4'd9; end
        default:      begin digit_hit = 1'b0; digit_val = 4'd0; end
      endcase
    end
    enter_hit = (code_in == KEY_ENTER);
    bksp_hit  = (code_in == KEY_BKSP) && !ext_q;
    esc_hit   = (code_in == KEY_ESC)  && !ext_q;
    key_byte  = code_valid && !brk_q && (code_in != BYTE_BRK) && (code_in != BYTE_EXT);
    key_any   = key_byte && (digit_hit || enter_hit || bksp_hit || esc_hit);
    code_shl  = (code_q << 4) | {{(DW-4){1'b0}}, digit_val};
  end

  // Next-state and output decode; key handling takes priority over timer expiry.
  always_comb begin
    state_n = state;
    code_n  = code_q;
    count_n = count_q;
    timer_n = timer_q;
    brk_n   = brk_q;
    ext_n   = ext_q;
    abort_n = 1'b0;

    // Prefix tracking is shared by IDLE and COLLECT; HOLD overrides it below.
    if (code_valid) begin
      if (code_in == BYTE_BRK) begin
        brk_n = 1'b1;
      end else if (code_in == BYTE_EXT) begin
        ext_n = 1'b1;
      end else begin
        brk_n = 1'b0;
        ext_n = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        if (key_byte && digit_hit) begin
          code_n  = {{(DW-4){1'b0}}, digit_val};
          count_n = CNT_ONE;
          state_n = COLLECT;
        end
      end

      COLLECT: begin
        if (key_any) begin
          timer_n = '0;
          if (digit_hit) begin
            if (count_q < CNT_FULL) begin
              code_n  = code_shl;
              count_n = count_q + CNT_ONE;
            end
          end else if (bksp_hit) begin
            code_n  = code_q >> 4;
            count_n = count_q - CNT_ONE;
            if (count_q == CNT_ONE) begin
              state_n = IDLE;
            end
          end else if (esc_hit) begin
            abort_n = 1'b1;
            code_n  = '0;
            count_n = '0;
            state_n = IDLE;
          end else begin
            // Enter: only a full entry is accepted, a short one is discarded.
            if (count_q == CNT_FULL) begin
              state_n = HOLD;
            end else begin
              abort_n = 1'b1;
              code_n  = '0;
              count_n = '0;
              state_n = IDLE;
            end
          end
        end else if (timer_q == TMR_LAST) begin
          abort_n = 1'b1;
          code_n  = '0;
          count_n = '0;
          state_n = IDLE;
        end else begin
          timer_n = timer_q + TMR_ONE;
        end
      end

      HOLD: begin
        brk_n = 1'b0;
        ext_n = 1'b0;
        if (entry_ack) begin
          code_n  = '0;
          count_n = '0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        code_n  = '0;
        count_n = '0;
        brk_n   = 1'b0;
        ext_n   = 1'b0;
      end
    endcase

    // The idle timer only ever runs inside COLLECT.
    if (state_n != COLLECT) begin
      timer_n = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state   <= IDLE;
      code_q  <= '0;
      count_q <= '0;
      timer_q <= '0;
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state   <= state_n;
      code_q  <= code_n;
      count_q <= count_n;
      timer_q <= timer_n;
      brk_q   <= brk_n;
      ext_q   <= ext_n;
      abort_q <= abort_n;
    end
  end

  assign entry_code  = code_q;
  assign digit_count = count_q;
  assign entry_abort = abort_q;
  assign entry_valid = (state == HOLD);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_keypad_entry_ctrl.sv
// Directed testbench for ps2_keypad_entry_ctrl, short timeout (20 cycles).
module tb_ps2_keypad_entry_ctrl;

  logic        sys_clk = 1'b0;
  logic        reset = 1'b1;
  logic        code_valid = 1'b0;
  logic [7:0]  code_in = 8'h00;
  logic        entry_ack = 1'b0;
  logic [15:0] entry_code;
  logic        entry_valid;
  logic        entry_abort;
  logic [2:0]  digit_count;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  ps2_keypad_entry_ctrl #(
    .NUM_DIGITS (4),
    .TIMEOUT_CYC(20),
    .TW         (5)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_in    (code_in),
    .entry_ack  (entry_ack),
    .entry_code (entry_code),
    .entry_valid(entry_valid),
    .entry_abort(entry_abort),
    .digit_count(digit_count),
    .busy       (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // All tasks start and end on a negedge; one posedge samples each driven value.
  task automatic send(input logic [7:0] b);
    code_valid = 1'b1;
    code_in    = b;
    @(negedge sys_clk);
    code_valid = 1'b0;
    code_in    = 8'h00;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    apply_reset();
    vectors++;
    if ({entry_code, entry_valid, entry_abort, digit_count, busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got code=%h valid=%b abort=%b count=%0d busy=%b, want all 0",
               entry_code, entry_valid, entry_abort, digit_count, busy);
    end
  endtask

  task automatic test_basic_entry();
    logic [2:0] exp_cnt [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] bytes   [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
    logic       held_ok;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      send(bytes[i]);
      vectors++;
      if (digit_count !== exp_cnt[i]) begin
        miscompares++;
        $display("FAIL basic_count[%0d]: got %0d want %0d", i, digit_count, exp_cnt[i]);
      end
    end
    send(8'h5A);
    vectors++;
    if (entry_valid !== 1'b1 || entry_code !== 16'h1234 || digit_count !== 3'd4 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold: got valid=%b code=%h count=%0d busy=%b, want 1 1234 4 1",
               entry_valid, entry_code, digit_count, busy);
    end
    held_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (entry_valid !== 1'b1 || entry_code !== 16'h1234) held_ok = 1'b0;
    end
    vectors++;
    if (held_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_hold_stable: got valid=%b code=%h, want 1 1234 for 10 cycles", entry_valid, entry_code);
    end
    entry_ack = 1'b1;
    @(negedge sys_clk);
    entry_ack = 1'b0;
    vectors++;
    if (entry_valid !== 1'b0 || entry_code !== 16'h0000 || digit_count !== 3'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ack: got valid=%b code=%h count=%0d busy=%b, want 0 0000 0 0",
               entry_valid, entry_code, digit_count, busy);
    end
  endtask

  task automatic test_break_codes();
    logic [7:0] bytes [6] = '{8'h16, 8'hF0, 8'h16, 8'h69, 8'hF0, 8'h69};
    apply_reset();
    for (int i = 0; i < 6; i++) send(bytes[i]);
    vectors++;
    if (entry_code !== 16'h0011 || digit_count !== 3'd2) begin
      miscompares++;
      $display("FAIL break_strip: got code=%h count=%0d, want 0011 2", entry_code, digit_count);
    end
  endtask

  task automatic test_bksp_short_enter();
    apply_reset();
    send(8'h16);
    send(8'h1E);
    send(8'h66);
    vectors++;
    if (entry_code !== 16'h0001 || digit_count !== 3'd1) begin
      miscompares++;
      $display("FAIL bksp: got code=%h count=%0d, want 0001 1", entry_code, digit_count);
    end
    send(8'h26);
    send(8'hE0);
    vectors++;
    if (entry_code !== 16'h0013 || digit_count !== 3'd2 || entry_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL bksp_retype: got code=%h count=%0d abort=%b, want 0013 2 0", entry_code, digit_count, entry_abort);
    end
    send(8'h5A);
    vectors++;
    if (entry_abort !== 1'b1 || busy !== 1'b0 || digit_count !== 3'd0 || entry_code !== 16'h0000 || entry_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_enter: got abort=%b busy=%b count=%0d code=%h valid=%b, want 1 0 0 0000 0",
               entry_abort, busy, digit_count, entry_code, entry_valid);
    end
    @(negedge sys_clk);
    vectors++;
    if (entry_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_width: got abort=%b one cycle later, want 0", entry_abort);
    end
    // Backspace of the only digit returns to IDLE.
    send(8'h25);
    send(8'h66);
    vectors++;
    if (busy !== 1'b0 || digit_count !== 3'd0 || entry_code !== 16'h0000 || entry_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL bksp_to_idle: got busy=%b count=%0d code=%h abort=%b, want 0 0 0000 0",
               busy, digit_count, entry_code, entry_abort);
    end
  endtask

  task automatic test_overflow_hold();
    logic [7:0] bytes [5] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    apply_reset();
    for (int i = 0; i < 5; i++) send(bytes[i]);
    vectors++;
    if (entry_code !== 16'h1234 || digit_count !== 3'd4) begin
      miscompares++;
      $display("FAIL overflow: got code=%h count=%0d, want 1234 4", entry_code, digit_count);
    end
    send(8'h5A);
    send(8'h16);
    send(8'h76);
    send(8'hF0);
    send(8'h66);
    vectors++;
    if (entry_valid !== 1'b1 || entry_code !== 16'h1234 || digit_count !== 3'd4 || entry_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_ignores: got valid=%b code=%h count=%0d abort=%b, want 1 1234 4 0",
               entry_valid, entry_code, digit_count, entry_abort);
    end
    // Byte together with ack is dropped; prefix state is clear afterwards.
    entry_ack = 1'b1;
    send(8'h16);
    entry_ack = 1'b0;
    send(8'h1E);
    vectors++;
    if (entry_valid !== 1'b0 || entry_code !== 16'h0002 || digit_count !== 3'd1) begin
      miscompares++;
      $display("FAIL ack_with_byte: got valid=%b code=%h count=%0d, want 0 0002 1",
               entry_valid, entry_code, digit_count);
    end
  endtask

  task automatic test_timeout();
    logic early;
    apply_reset();
    send(8'h16);
    early = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge sys_clk);
      if (entry_abort !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_early: got early_abort=%b busy=%b, want 0 1", early, busy);
    end
    @(negedge sys_clk);
    vectors++;
    if (entry_abort !== 1'b1 || busy !== 1'b0 || digit_count !== 3'd0) begin
      miscompares++;
      $display("FAIL timeout_fire: got abort=%b busy=%b count=%0d, want 1 0 0", entry_abort, busy, digit_count);
    end

    // Key at cycle 19 restarts the count.
    apply_reset();
    send(8'h16);
    for (int i = 1; i < 19; i++) @(negedge sys_clk);
    send(8'h1E);
    early = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge sys_clk);
      if (entry_abort !== 1'b0) early = 1'b1;
    end
    vectors++;
    if (early !== 1'b0 || entry_code !== 16'h0012 || digit_count !== 3'd2) begin
      miscompares++;
      $display("FAIL timeout_restart: got early_abort=%b code=%h count=%0d, want 0 0012 2",
               early, entry_code, digit_count);
    end
    @(negedge sys_clk);
    vectors++;
    if (entry_abort !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_restart_fire: got abort=%b busy=%b, want 1 0", entry_abort, busy);
    end

    // Key in the very cycle the timer expires wins.
    apply_reset();
    send(8'h16);
    for (int i = 1; i < 20; i++) @(negedge sys_clk);
    send(8'h1E);
    vectors++;
    if (entry_abort !== 1'b0 || digit_count !== 3'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL key_vs_expiry: got abort=%b count=%0d busy=%b, want 0 2 1", entry_abort, digit_count, busy);
    end
  endtask

  task automatic test_reset_override();
    apply_reset();
    send(8'h16);
    send(8'h1E);
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    vectors++;
    if ({entry_code, entry_valid, entry_abort, digit_count, busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_collect: got code=%h valid=%b abort=%b count=%0d busy=%b, want all 0",
               entry_code, entry_valid, entry_abort, digit_count, busy);
    end
    send(8'h45);
    send(8'h46);
    send(8'h3E);
    send(8'h3D);
    send(8'h5A);
    vectors++;
    if (entry_valid !== 1'b1 || entry_code !== 16'h0987) begin
      miscompares++;
      $display("FAIL zero_nine_entry: got valid=%b code=%h, want 1 0987", entry_valid, entry_code);
    end
    reset = 1'b1;
    @(negedge sys_clk);
    reset = 1'b0;
    vectors++;
    if ({entry_code, entry_valid, entry_abort, digit_count, busy} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_hold: got code=%h valid=%b abort=%b count=%0d busy=%b, want all 0",
               entry_code, entry_valid, entry_abort, digit_count, busy);
    end
    send(8'h76);
    vectors++;
    if (entry_abort !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL esc_in_idle: got abort=%b busy=%b, want 0 0", entry_abort, busy);
    end
    // Extended keypad digit is not a digit.
    send(8'hE0);
    send(8'h69);
    vectors++;
    if (busy !== 1'b0 || digit_count !== 3'd0) begin
      miscompares++;
      $display("FAIL ext_digit: got busy=%b count=%0d, want 0 0", busy, digit_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_break_codes();
    test_bksp_short_enter();
    test_overflow_hold();
    test_timeout();
    test_reset_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
